// File: rtl/mux2_sel_reg_pkg.sv
// mux2_sel_reg_pkg
//   Shared constants for the 2:1 selector block.
//   DATA_W : default datapath word width.
package mux2_sel_reg_pkg;
  localparam int DATA_W = 64;
endpackage

// File: rtl/mux2_sel_reg_cell.sv
// mux2_cell
//   1-bit combinational 2:1 mux, the leaf of every selector in this block.
//   i0  : value passed when sel=0
//   i1  : value passed when sel=1
//   sel : select
//   out : (i1 & sel) | (i0 & ~sel)
module mux2_cell (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic out
);
  // The (i0 & i1) consensus term is logically redundant. It lets an unknown
  // sel resolve to the shared value when both inputs agree.
  assign out = (i1 & sel) | (i0 & ~sel) | (i0 & i1);
endmodule

// File: rtl/mux2_sel_reg.sv
// mux2_sel_reg
//   Word and bit 2:1 selectors. Each has a combinational output and a
//   registered copy. The registers share one load enable.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i0, i1, sel     : word inputs and select; out = sel ? i1 : i0
//   out_q           : registered out
//   bi0, bi1, bsel  : bit inputs and select; bout = bsel ? bi1 : bi0
//   bout_q          : registered bout
//   en              : load enable for out_q and bout_q
module mux2_sel_reg
  import mux2_sel_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  input  logic             bi0,
  input  logic             bi1,
  input  logic             bsel,
  output logic             bout,
  output logic             bout_q,
  input  logic             en
);

  // Word path: one cell per bit, all driven by the same select.
  for (genvar g = 0; g < WIDTH; g++) begin : g_word
    mux2_cell u_cell (
      .i0  (i0[g]),
      .i1  (i1[g]),
      .sel (sel),
      .out (out[g])
    );
  end

  mux2_cell u_bit (
    .i0  (bi0),
    .i1  (bi1),
    .sel (bsel),
    .out (bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      bout_q <= 1'b0;
    end else if (en) begin
      out_q  <= out;
      bout_q <= bout;
    end
  end

endmodule

// File: tb/tb_mux2_sel_reg.sv
module tb_mux2_sel_reg;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i0, i1, out, out_q;
  logic         sel, bi0, bi1, bsel, bout, bout_q, en;

  int total = 0;
  int bad   = 0;

  mux2_sel_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0(i0), .i1(i1), .sel(sel), .out(out), .out_q(out_q),
    .bi0(bi0), .bi1(bi1), .bsel(bsel), .bout(bout), .bout_q(bout_q),
    .en(en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]   btab;
    logic [W-1:0] xexp;
    // expected bout indexed by {bsel,bi1,bi0}
    btab = 8'b1100_1010;
    xexp = {56'h0, 4'hx, 4'hf};

    rst_n = 1'b0; en = 1'b1; sel = 1'b0; bsel = 1'b0;
    i0 = '0; i1 = '0; bi0 = 1'b0; bi1 = 1'b0;
    #2;
    chk("rst_out_q", out_q, '0);
    chk("rst_bout_q", {63'h0, bout_q}, '0);
    @(negedge clk); rst_n = 1'b1; en = 1'b0;

    // word selection
    sel = 1'b0; i0 = 64'd100; i1 = '0; #1 chk("sel0_100", out, 64'd100);
    sel = 1'b1; #1 chk("sel1_0", out, 64'd0);
    i1 = 64'h3; #1 chk("sel1_3", out, 64'd3);

    // bit-position independence
    i0 = '1; i1 = '0;
    sel = 1'b0; #1 chk("ones_sel0", out, 64'hFFFF_FFFF_FFFF_FFFF);
    sel = 1'b1; #1 chk("ones_sel1", out, 64'd0);
    for (int k = 0; k < W; k++) begin
      i1 = 64'd1 << k;
      #1 chk($sformatf("walk%0d", k), out, 64'd1 << k);
    end

    // bit path, all combinations
    for (int c = 0; c < 8; c++) begin
      {bsel, bi1, bi0} = c[2:0];
      #1 chk($sformatf("bit%0d", c), {63'h0, bout}, {63'h0, btab[c]});
    end

    // enable hold
    @(negedge clk); en = 1'b1; i0 = 64'd111; sel = 1'b0;
    @(posedge clk); #1 chk("en_load", out_q, 64'd111);
    @(negedge clk); en = 1'b0; i0 = 64'd2;
    @(posedge clk); #1 chk("en_hold", out_q, 64'd111);
    chk("en_hold_out", out, 64'd2);

    // asynchronous reset mid-cycle
    @(negedge clk); en = 1'b1; i0 = 64'd7; sel = 1'b0; bi0 = 1'b1; bi1 = 1'b0; bsel = 1'b0;
    @(posedge clk); #1 chk("pre_rst_q", out_q, 64'd7);
    chk("pre_rst_bq", {63'h0, bout_q}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_q", out_q, '0);
    chk("async_rst_bq", {63'h0, bout_q}, '0);
    chk("rst_out_live", out, 64'd7);
    chk("rst_bout_live", {63'h0, bout}, 64'd1);
    @(posedge clk); #1 chk("rst_hold_q", out_q, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 chk("rel_load_q", out_q, 64'd7);
    chk("rel_load_bq", {63'h0, bout_q}, 64'd1);

    // equal inputs with sel toggling
    @(negedge clk); i0 = 64'h5; i1 = 64'h5; en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      sel = ~sel;
      #1 chk($sformatf("eq_t%0d", t), out, 64'h5);
      #9;
    end
    en = 1'b1;
    @(posedge clk); #1 chk("eq_q", out_q, 64'h5);

    // unknown select: differing bits go X, agreeing bits resolve
    @(negedge clk); en = 1'b0; i0 = 64'h0F; i1 = 64'hFF; sel = 1'bx;
    #1 chk("sel_x", out, xexp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
